// File: rtl/capture_sequencer_if.sv
// Sensor-side and pixel-side signal bundle for capture_sequencer.
// The master modport is the sensor/controller side; the slave modport is the sequencer.
interface capture_sequencer_if;

    logic        iSTART;
    logic        iSTOP;
    logic        iFVAL;
    logic        iLVAL;
    logic [11:0] iDATA;

    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oFIFO_CLR;
    logic        oBUSY;
    logic [1:0]  oERR;

    modport master (
        output iSTART, iSTOP, iFVAL, iLVAL, iDATA,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oFIFO_CLR, oBUSY, oERR
    );

    modport slave (
        input  iSTART, iSTOP, iFVAL, iLVAL, iDATA,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oFIFO_CLR, oBUSY, oERR
    );

endinterface

// File: rtl/capture_sequencer.sv
// Frame capture sequencer: waits for a whole sensor frame, forwards line pixels with
// column/row indices, counts frames, and pulses a row-FIFO clear between frames.
module capture_sequencer #(
    parameter int unsigned COLUMN_WIDTH = 1280,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    capture_sequencer_if.slave bus
);

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned CNT_W   = 11;
    localparam int unsigned FRAME_W = 32;
    localparam int unsigned FLUSH_W = 4;

    localparam logic [CNT_W-1:0]   COL_MAX    = CNT_W'(COLUMN_WIDTH);
    localparam logic [CNT_W-1:0]   ROW_MAX    = {CNT_W{1'b1}};
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SOF = 2'd1;
    localparam logic [1:0] S_ACTIVE   = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    logic [1:0]         state,     state_n;
    logic               fval_d,    lval_d;
    logic [CNT_W-1:0]   col_cnt,   col_n;
    logic [CNT_W-1:0]   row_cnt,   row_n;
    logic [FLUSH_W-1:0] flush_cnt, flush_n;
    logic               stop_pend, stop_n;
    logic [DATA_W-1:0]  data_q,    data_n;
    logic               dval_q,    dval_n;
    logic [CNT_W-1:0]   x_q,       x_n;
    logic [CNT_W-1:0]   y_q,       y_n;
    logic [FRAME_W-1:0] frame_q,   frame_n;
    logic               clr_q,     clr_n;
    logic               busy_q,    busy_n;
    logic [1:0]         err_q,     err_n;

    logic             fval_rise, fval_fall, line_end, pix_in, accept;
    logic [CNT_W-1:0] row_inc, row_final;

    assign fval_rise = bus.iFVAL & ~fval_d;
    assign fval_fall = ~bus.iFVAL & fval_d;
    assign line_end  = lval_d & (~bus.iLVAL | ~bus.iFVAL);
    assign pix_in    = (state == S_ACTIVE) & bus.iFVAL & bus.iLVAL & ~fval_rise;
    assign accept    = pix_in & (col_cnt != COL_MAX);
    assign row_inc   = (row_cnt == ROW_MAX) ? row_cnt : row_cnt + CNT_W'(1);
    // Row count as it will stand after this cycle, used for the frame-end parity check
    assign row_final = line_end ? row_inc : row_cnt;

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        col_n   = col_cnt;
        row_n   = row_cnt;
        flush_n = flush_cnt;
        stop_n  = stop_pend;
        data_n  = data_q;
        dval_n  = 1'b0;
        x_n     = x_q;
        y_n     = y_q;
        frame_n = frame_q;
        clr_n   = 1'b0;
        err_n   = err_q;

        if (line_end) begin
            col_n = '0;
        end

        case (state)
            S_IDLE: begin
                if (bus.iSTART && !bus.iSTOP) begin
                    state_n = S_WAIT_SOF;
                    err_n   = 2'b00;
                end
            end
            S_WAIT_SOF: begin
                if (bus.iSTOP) begin
                    state_n = S_IDLE;
                end else if (fval_rise) begin
                    state_n = S_ACTIVE;
                    row_n   = '0;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    dval_n = 1'b1;
                    data_n = bus.iDATA;
                    x_n    = col_cnt;
                    y_n    = row_cnt;
                    col_n  = col_cnt + CNT_W'(1);
                end else if (pix_in) begin
                    err_n[0] = 1'b1;
                end
                if (line_end) begin
                    row_n = row_inc;
                    if (col_cnt != COL_MAX) begin
                        err_n[0] = 1'b1;
                    end
                end
                if (bus.iSTOP) begin
                    stop_n = 1'b1;
                end
                if (fval_fall) begin
                    state_n = S_FLUSH;
                    flush_n = '0;
                    frame_n = frame_q + FRAME_W'(1);
                    if (row_final[0] || (row_final == '0)) begin
                        err_n[1] = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                // First FLUSH cycle keeps the clear low so the pulse lies wholly inside FLUSH
                if (flush_cnt == FLUSH_LAST) begin
                    state_n = stop_pend ? S_IDLE : S_WAIT_SOF;
                    stop_n  = 1'b0;
                end else begin
                    flush_n = flush_cnt + FLUSH_W'(1);
                    clr_n   = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= S_IDLE;
            fval_d    <= 1'b0;
            lval_d    <= 1'b0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            flush_cnt <= '0;
            stop_pend <= 1'b0;
            data_q    <= '0;
            dval_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= '0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            state     <= state_n;
            fval_d    <= bus.iFVAL;
            lval_d    <= bus.iLVAL;
            col_cnt   <= col_n;
            row_cnt   <= row_n;
            flush_cnt <= flush_n;
            stop_pend <= stop_n;
            data_q    <= data_n;
            dval_q    <= dval_n;
            x_q       <= x_n;
            y_q       <= y_n;
            frame_q   <= frame_n;
            clr_q     <= clr_n;
            busy_q    <= busy_n;
            err_q     <= err_n;
        end
    end

    assign bus.oDATA       = data_q;
    assign bus.oDVAL       = dval_q;
    assign bus.oX_Cont     = x_q;
    assign bus.oY_Cont     = y_q;
    assign bus.oFrame_Cont = frame_q;
    assign bus.oFIFO_CLR   = clr_q;
    assign bus.oBUSY       = busy_q;
    assign bus.oERR        = err_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scenario bench for capture_sequencer with a pixel scoreboard (COLUMN_WIDTH=8, FLUSH_CYCLES=4).
module tb_capture_sequencer;

    localparam int unsigned COLS  = 8;
    localparam int unsigned FLUSH = 4;

    typedef struct packed {
        logic [11:0] data;
        logic [10:0] x;
        logic [10:0] y;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    capture_sequencer_if bus();

    capture_sequencer #(.COLUMN_WIDTH(COLS), .FLUSH_CYCLES(FLUSH)) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    pix_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          clr_seen = 0;
    int          exp_frames = 0;

    // One clock: inputs sampled at posedge, outputs observed and scored at negedge
    task automatic tick();
        pix_t got, exp;
        @(posedge clk);
        @(negedge clk);
        if (bus.oFIFO_CLR) clr_seen++;
        if (bus.oDVAL) begin
            n_checks++;
            got = '{data: bus.oDATA, x: bus.oX_Cont, y: bus.oY_Cont};
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_unexpected: got data=%h x=%0d y=%0d, required no oDVAL", got.data, got.x, got.y);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL pixel: got data=%h x=%0d y=%0d, required data=%h x=%0d y=%0d",
                             got.data, got.x, got.y, exp.data, exp.x, exp.y);
                end
            end
        end
    endtask

    task automatic pulse_start(input logic stop_too);
        bus.iSTART = 1'b1;
        bus.iSTOP  = stop_too;
        tick();
        bus.iSTART = 1'b0;
        bus.iSTOP  = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.iSTOP = 1'b1;
        tick();
        bus.iSTOP = 1'b0;
    endtask

    // Full frame; long_line gets 10 pixels, stop_line gets an iSTOP on its first pixel
    task automatic drive_frame(input int nlines, input logic capture, input int long_line, input int stop_line);
        int npix;
        bus.iFVAL = 1'b1;
        bus.iLVAL = 1'b0;
        tick();
        for (int l = 0; l < nlines; l++) begin
            npix = (l == long_line) ? 10 : int'(COLS);
            for (int i = 0; i < npix; i++) begin
                bus.iLVAL = 1'b1;
                bus.iDATA = 12'($urandom);
                bus.iSTOP = (l == stop_line) && (i == 0);
                if (capture && (i < int'(COLS)))
                    sb_q.push_back('{data: bus.iDATA, x: 11'(i), y: 11'(l)});
                tick();
                bus.iSTOP = 1'b0;
            end
            bus.iLVAL = 1'b0;
            tick();
            tick();
        end
        bus.iFVAL = 1'b0;
        tick();
        if (capture) exp_frames++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_frame_end(input string name, input logic [1:0] exp_err, input logic exp_busy);
        n_checks++;
        if (bus.oFrame_Cont !== 32'(exp_frames)) begin
            n_fail++;
            $display("FAIL %s_frames: got %0d, required %0d", name, bus.oFrame_Cont, exp_frames);
        end
        n_checks++;
        if (clr_seen !== int'(FLUSH)) begin
            n_fail++;
            $display("FAIL %s_fifo_clr: got %0d cycles, required %0d", name, clr_seen, FLUSH);
        end
        n_checks++;
        if (bus.oERR !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err: got %b, required %b", name, bus.oERR, exp_err);
        end
        n_checks++;
        if (bus.oBUSY !== exp_busy) begin
            n_fail++;
            $display("FAIL %s_busy: got %b, required %b", name, bus.oBUSY, exp_busy);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_pixels: got %0d outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({bus.oDATA, bus.oDVAL, bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont,
             bus.oFIFO_CLR, bus.oBUSY, bus.oERR} !== '0) begin
            n_fail++;
            $display("FAIL %s_outputs: got data=%h dval=%b x=%0d y=%0d frame=%0d clr=%b busy=%b err=%b, required all 0",
                     name, bus.oDATA, bus.oDVAL, bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont,
                     bus.oFIFO_CLR, bus.oBUSY, bus.oERR);
        end
    endtask

    task automatic test_reset();
        bus.iSTART = 1'b0; bus.iSTOP = 1'b0; bus.iFVAL = 1'b0;
        bus.iLVAL  = 1'b0; bus.iDATA = '0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check_all_zero("reset");
    endtask

    task automatic test_basic();
        pulse_start(1'b0);
        n_checks++;
        if (bus.oBUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_after_start: got %b, required 1", bus.oBUSY);
        end
        clr_seen = 0;
        drive_frame(4, 1'b1, -1, -1);
        idle(10);
        check_frame_end("basic", 2'b00, 1'b1);
    endtask

    task automatic test_mid_frame_start();
        pulse_stop();
        n_checks++;
        if (bus.oBUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL midstart_stop_wait: got busy=%b, required 0", bus.oBUSY);
        end
        bus.iFVAL = 1'b1;
        idle(3);
        pulse_start(1'b0);
        for (int l = 0; l < 2; l++) begin
            bus.iLVAL = 1'b1;
            for (int i = 0; i < int'(COLS); i++) begin
                bus.iDATA = 12'($urandom);
                tick();
            end
            bus.iLVAL = 1'b0;
            idle(2);
        end
        bus.iFVAL = 1'b0;
        idle(3);
        clr_seen = 0;
        drive_frame(2, 1'b1, -1, -1);
        idle(10);
        check_frame_end("midstart", 2'b00, 1'b1);
    endtask

    task automatic test_long_line();
        clr_seen = 0;
        drive_frame(4, 1'b1, 1, -1);
        idle(10);
        check_frame_end("long_line", 2'b01, 1'b1);
    endtask

    task automatic test_short_frame();
        pulse_stop();
        pulse_start(1'b0);
        n_checks++;
        if (bus.oERR !== 2'b00) begin
            n_fail++;
            $display("FAIL short_err_clear_on_start: got %b, required 00", bus.oERR);
        end
        clr_seen = 0;
        drive_frame(3, 1'b1, -1, -1);
        idle(10);
        check_frame_end("short_frame", 2'b10, 1'b1);
        pulse_stop();
        pulse_start(1'b0);
        n_checks++;
        if (bus.oERR !== 2'b00) begin
            n_fail++;
            $display("FAIL short_err_restart: got %b, required 00", bus.oERR);
        end
    endtask

    task automatic test_stop_active();
        clr_seen = 0;
        drive_frame(4, 1'b1, -1, 2);
        idle(10);
        check_frame_end("stop_active", 2'b00, 1'b0);
        drive_frame(4, 1'b0, -1, -1);
        idle(10);
        n_checks++;
        if (bus.oFrame_Cont !== 32'(exp_frames) || bus.oBUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_ignored_frame: got frame=%0d busy=%b, required frame=%0d busy=0",
                     bus.oFrame_Cont, bus.oBUSY, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_start(1'b0);
        bus.iFVAL = 1'b1;
        tick();
        bus.iLVAL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.iDATA = 12'($urandom);
            sb_q.push_back('{data: bus.iDATA, x: 11'(i), y: 11'(0)});
            tick();
        end
        rst = 1'b1;
        bus.iDATA = 12'($urandom);
        tick();
        rst = 1'b0;
        exp_frames = 0;
        check_all_zero("reset_mid");
        bus.iFVAL = 1'b0;
        bus.iLVAL = 1'b0;
        pulse_start(1'b1);
        n_checks++;
        if (bus.oBUSY !== 1'b0 || bus.oERR !== 2'b00) begin
            n_fail++;
            $display("FAIL start_stop_coincide: got busy=%b err=%b, required busy=0 err=00", bus.oBUSY, bus.oERR);
        end
        bus.iFVAL = 1'b1;
        idle(2);
        bus.iFVAL = 1'b0;
        idle(8);
        check_all_zero("idle_after_reset");
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_missing_pixels: got %0d outstanding, required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_frame_start();
        test_long_line();
        test_short_frame();
        test_stop_active();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter COLUMN_WIDTH, default 1280: expected pixels per sensor line (range 2..2047).
REQ-002 Parameter FLUSH_CYCLES, default 4: length of the inter-frame line-buffer clear pulse (range 1..15).
REQ-003 iCLK  input  1  pixel clock; all state changes on the rising edge.
REQ-004 iRST  input  1  synchronous, active-high reset.
REQ-005 iSTART  input  1  capture start request; single-cycle pulse.
REQ-006 iSTOP  input  1  capture stop request; single-cycle pulse.
REQ-007 iFVAL  input  1  sensor frame valid.
REQ-008 iLVAL  input  1  sensor line valid.
REQ-009 iDATA  input  12  sensor RAW Bayer sample.
REQ-010 oDATA  output  12  registered pixel sample.
REQ-011 oDVAL  output  1  oDATA is a captured pixel.
REQ-012 oX_Cont  output  11  column index of oDATA.
REQ-013 oY_Cont  output  11  row index of oDATA; bit 0 selects buffer write or merge in the downstream Bayer-to-RGB stage.
REQ-014 oFrame_Cont  output  32  number of completed captured frames.
REQ-015 oFIFO_CLR  output  1  clear pulse for the downstream row FIFO.
REQ-016 oBUSY  output  1  high when the FSM is not in IDLE.
REQ-017 oERR  output  2  sticky errors: bit 0 = line-length error, bit 1 = odd or zero row count.

Function
REQ-018 The FSM SHALL have four states: IDLE, WAIT_SOF, ACTIVE and FLUSH.
REQ-019 The FSM SHALL register iFVAL and iLVAL once per cycle as fval_d and lval_d for edge detection.
  - FVAL rise = iFVAL & !fval_d.
  - FVAL fall = !iFVAL & fval_d.
  - Line end = lval_d & (!iLVAL | !iFVAL).
REQ-020 IDLE SHALL move to WAIT_SOF on iSTART & !iSTOP; when iSTART and iSTOP coincide, stop wins and the FSM stays in IDLE.
REQ-021 On any iSTART accepted in IDLE, the block SHALL clear oERR.
REQ-022 iSTART SHALL be ignored in all states other than IDLE.
REQ-023 WAIT_SOF SHALL move to ACTIVE on FVAL rise.
  - A start issued mid-frame therefore waits for the next whole frame.
  - iSTOP in WAIT_SOF SHALL return the FSM to IDLE on the next edge.
REQ-024 A pixel SHALL be accepted only in a cycle where the state is ACTIVE and iFVAL & iLVAL are high; the FVAL-rise cycle itself is not accepted.
REQ-025 An accepted pixel SHALL produce, one cycle later, oDVAL=1, oDATA=iDATA, oX_Cont=current column count and oY_Cont=current row count.
  - Latency is exactly 1 cycle.
  - In all other cycles oDVAL=0 and oDATA, oX_Cont, oY_Cont hold their last values.
REQ-026 The column count SHALL increment on each accepted pixel and clear to 0 at every line end.
REQ-027 When the column count reaches COLUMN_WIDTH within a line, further pixels in that line SHALL be dropped (oDVAL=0) and oERR[0] SHALL be set.
REQ-028 At a line end in ACTIVE where the column count is not equal to COLUMN_WIDTH, oERR[0] SHALL be set.
REQ-029 The row count SHALL increment at every line end in ACTIVE, saturate at 2047, and clear to 0 on entry to ACTIVE.
REQ-030 A line cut short by FVAL fall while iLVAL is high SHALL count as a line end.
REQ-031 On FVAL fall in ACTIVE, the FSM SHALL move to FLUSH and oFrame_Cont SHALL increment by 1, wrapping at 2^32.
  - oERR[1] SHALL be set if the final row count is odd or zero.
  - The final row count includes any line end in the same cycle.
REQ-032 iSTOP in ACTIVE SHALL set a stop-pending flag; the frame in progress completes normally.
REQ-033 FLUSH SHALL drive oFIFO_CLR=1 for exactly FLUSH_CYCLES cycles, starting the cycle after entry.
  - It SHALL then move to IDLE if stop is pending (clearing the flag), else to WAIT_SOF.
REQ-034 In FLUSH the block SHALL not accept pixels and SHALL ignore FVAL rise; a new frame is caught only from WAIT_SOF.
REQ-035 oFIFO_CLR SHALL be 0 in every state except FLUSH.
REQ-036 oBUSY SHALL be registered and track the state, i.e. 1 in WAIT_SOF, ACTIVE and FLUSH.
REQ-037 oERR bits SHALL remain set until iRST or an accepted iSTART.

Reset
REQ-038 While iRST=1 at a clock edge:
  - The state SHALL become IDLE.
  - All counters, fval_d, lval_d and the stop-pending flag SHALL clear to 0.
  - Every output (oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oFIFO_CLR, oBUSY, oERR) SHALL be 0.
REQ-039 Reset SHALL take priority over all other inputs, including mid-frame or during FLUSH; no oFrame_Cont increment or oFIFO_CLR pulse completes.

Verification
REQ-040 Basic capture: iSTART, then a 4-line frame of 1280-pixel lines -> 5120 oDVAL pulses, oX_Cont 0..1279 per line, oY_Cont 0..3, oFrame_Cont=1, oFIFO_CLR high for 4 cycles, oERR=0.
REQ-041 Mid-frame start: iSTART while iFVAL=1 -> no oDVAL until the next FVAL rise; the next frame is captured from oY_Cont=0.
REQ-042 Long line: COLUMN_WIDTH=8, a line of 10 pixels -> 8 oDVAL pulses on that line and oERR[0]=1.
REQ-043 Short frame: 3 lines -> oERR[1]=1 at frame end; a later iSTART from IDLE clears oERR to 0.
REQ-044 Stop during ACTIVE: iSTOP at line 2 -> frame completes, oFrame_Cont increments, FLUSH runs, FSM returns to IDLE (oBUSY=0), and the next frame is ignored.
REQ-045 Reset mid-frame, plus simultaneous iSTART and iSTOP in IDLE -> all outputs 0 the cycle after reset; FSM stays in IDLE with oBUSY=0.
